// File: rtl/hexdisp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hexdisp_pkg
// Description : Shared constants for the hex display driver. Holds the
//               blank code, the 0..F segment table (active-low gfedcba) and
//               the nibble-to-segment lookup function.
// Revision    : 1.0 - initial release
// ============================================================================
package hexdisp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the code for hex digit n (entry 0 sits in the LSBs).
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        return SEG_CODES[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_lut.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg_lut
// Description : Combinational 4-bit to 7-segment (active-low gfedcba) lookup.
// Ports       : nibble - hex digit in
//               seg    - segment code out
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg_lut
    import hexdisp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = nibble_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_ctrl
// Description : Registered driver for NUM_DIGITS active-low seven-segment hex
//               digits with value latch, leading-zero suppression and
//               per-digit blinking paced by an internal prescaler.
//               Optional macro HEXDISP_SCAN_EN selects multiplexed scan mode
//               (single 7-bit seg bus plus active-low digit select an).
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               load       - capture strobe for value
//               value      - packed nibbles, nibble 0 = rightmost digit
//               blank_lz   - suppress leading zeros (live)
//               blink_mask - per-digit blink enable (live)
//               seg        - segment codes (7*NUM_DIGITS static, 7 in scan)
//               an         - active-low digit select (scan mode only)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
    import hexdisp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef HEXDISP_SCAN_EN
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
`else
    output logic [7*NUM_DIGITS-1:0] seg
`endif
);

    localparam int BW = $clog2(BLINK_DIV);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   digit_blank;

    // Digit i is a leading zero when it and every digit above it are zero.
    // Digit 0 is excluded so a zero value still shows one "0".
    always_comb begin
        lz_blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_blank[i] = blank_lz;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (value_q[4*j +: 4] != 4'h0) begin
                    lz_blank[i] = 1'b0;
                end
            end
        end
    end

    assign digit_blank = lz_blank | (blink_mask & {NUM_DIGITS{~blink_phase}});

    // Value latch and blink prescaler. A load restarts the blink period in
    // the visible phase and takes priority over the terminal-count toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (load) begin
            value_q     <= value;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

`ifdef HEXDISP_SCAN_EN
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [3:0]    sel_nibble;
    logic          sel_blank;
    logic [6:0]    sel_code;

    always_comb begin
        sel_nibble = 4'h0;
        sel_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                sel_nibble = value_q[4*i +: 4];
                sel_blank  = digit_blank[i];
            end
        end
    end

    hex7seg_lut u_lut (
        .nibble (sel_nibble),
        .seg    (sel_code)
    );

    // seg and an are registered from the same scan index so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg      <= SEG_BLANK;
            an       <= '1;
        end else begin
            seg <= sel_blank ? SEG_BLANK : sel_code;
            an  <= ~(NUM_DIGITS'(1) << scan_idx);
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end
`else
    logic [7*NUM_DIGITS-1:0] code;
    logic [7*NUM_DIGITS-1:0] seg_next;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        hex7seg_lut u_lut (
            .nibble (value_q[4*i +: 4]),
            .seg    (code[7*i +: 7])
        );
        assign seg_next[7*i +: 7] = digit_blank[i] ? SEG_BLANK : code[7*i +: 7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '1;
        end else begin
            seg <= seg_next;
        end
    end
`endif

endmodule
`default_nettype wire
